controlador_7seg: RTL and testbench

Multiplexed seven-segment display driver placed directly downstream of `cargador_N_bits`. It takes the latched N-bit number and shows it in hexadecimal on a 4-digit common-anode display, scanning one digit at a time at a parameterised refresh rate. It also provides optional leading-zero blanking and per-digit decimal points. The number is snapshotted once per scan frame, so a load in mid-frame never shows a torn value.

---
 rtl/controlador_7seg_pkg.sv | 38 +++
 rtl/controlador_7seg_decodificador.sv | 37 +++
 rtl/controlador_7seg.sv | 137 +++++++++++++
 tb/tb_controlador_7seg.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/controlador_7seg_pkg.sv
// -----------------------------------------------------------------------------
// controlador_7seg_pkg
// Shared constants for the multiplexed seven-segment driver:
//   - active-low hex font, segment order {g,f,e,d,c,b,a}
//   - blank pattern and "all anodes off" pattern
//   - default refresh divider (1 kHz digit rate at 50 MHz)
//   - helper that turns a digit index into its one-hot-low anode pattern
// -----------------------------------------------------------------------------
package controlador_7seg_pkg;

    localparam int DIV_REFRESCO_DEF = 50000;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;  // lowercase b
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;  // lowercase d
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_APAGADO = 7'h7F;
    localparam logic [3:0] ANODOS_OFF  = 4'b1111;

    // One-hot-low anode enable for digit idx (bit 0 = least significant digit).
    function automatic logic [3:0] anodo_activo(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/controlador_7seg_decodificador.sv
// -----------------------------------------------------------------------------
// decodificador_hex_7seg
// Purely combinational hex-to-seven-segment decoder, active-low outputs.
//   nibble    in  4 : hex digit 0..F
//   segmentos out 7 : {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module decodificador_hex_7seg
    import controlador_7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segmentos
);

    always_comb begin
        segmentos = SEG_APAGADO;
        unique case (nibble)
            4'h0: segmentos = SEG_0;
            4'h1: segmentos = SEG_1;
            4'h2: segmentos = SEG_2;
            4'h3: segmentos = SEG_3;
            4'h4: segmentos = SEG_4;
            4'h5: segmentos = SEG_5;
            4'h6: segmentos = SEG_6;
            4'h7: segmentos = SEG_7;
            4'h8: segmentos = SEG_8;
            4'h9: segmentos = SEG_9;
            4'hA: segmentos = SEG_A;
            4'hB: segmentos = SEG_B;
            4'hC: segmentos = SEG_C;
            4'hD: segmentos = SEG_D;
            4'hE: segmentos = SEG_E;
            4'hF: segmentos = SEG_F;
            default: segmentos = SEG_APAGADO;
        endcase
    end

endmodule

// File: rtl/controlador_7seg.sv
// -----------------------------------------------------------------------------
// controlador_7seg
// Scans a 4-digit common-anode display showing `numero` in hex.
//   clk            in   1 : system clock, rising edge
//   reset          in   1 : asynchronous, active-high
//   numero         in  16 : value to display
//   suprimir_ceros in   1 : 1 = blank leading zero digits (digit 0 never blank)
//   punto_en       in   4 : decimal point request per digit
//   anodos         out  4 : digit enables, active-low, bit 0 = LS digit
//   segmentos      out  7 : {g,f,e,d,c,b,a}, active-low
//   punto          out  1 : decimal point, active-low
// The inputs are snapshotted once per frame (at the edge that selects digit 0)
// so a mid-frame change of `numero` never produces a torn display.
// -----------------------------------------------------------------------------
module controlador_7seg
    import controlador_7seg_pkg::*;
#(
    parameter int CANT_BITS    = 16,
    parameter int DIV_REFRESCO = DIV_REFRESCO_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CANT_BITS-1:0] numero,
    input  logic                 suprimir_ceros,
    input  logic [3:0]           punto_en,
    output logic [3:0]           anodos,
    output logic [6:0]           segmentos,
    output logic                 punto
);

    localparam int CW = $clog2(DIV_REFRESCO);
    localparam logic [CW-1:0] CUENTA_MAX = CW'(DIV_REFRESCO - 1);

    // State
    logic [CW-1:0]        contador_q, contador_d;
    logic [1:0]           indice_q, indice_d;
    logic [CANT_BITS-1:0] copia_q, copia_d;
    logic                 copia_sup_q, copia_sup_d;
    logic [3:0]           copia_pto_q, copia_pto_d;
    logic [3:0]           anodos_q, anodos_d;
    logic [6:0]           segmentos_q, segmentos_d;
    logic                 punto_q, punto_d;

    // Datapath
    logic                 tick;
    logic                 inicio_cuadro;
    logic [CANT_BITS-1:0] num_sel;
    logic                 sup_sel;
    logic [3:0]           pto_sel;
    logic [3:0]           nibble;
    logic [6:0]           seg_fuente;
    logic [3:0]           nib_cero;
    logic [3:0]           ceros_arriba;
    logic                 blanco;

    assign tick          = (contador_q == CUENTA_MAX);
    assign inicio_cuadro = tick && (indice_d == 2'd0);

    // Digit 0 is shown on the very edge that takes the snapshot, so it must
    // read the live inputs; the remaining digits read the frozen copy.
    assign num_sel = inicio_cuadro ? numero         : copia_q;
    assign sup_sel = inicio_cuadro ? suprimir_ceros : copia_sup_q;
    assign pto_sel = inicio_cuadro ? punto_en       : copia_pto_q;

    assign nibble = num_sel[{indice_d, 2'b00} +: 4];

    decodificador_hex_7seg u_deco (
        .nibble    (nibble),
        .segmentos (seg_fuente)
    );

    // ceros_arriba[i] = nibbles i..3 are all zero (leading-zero run reaches i).
    always_comb begin
        nib_cero     = '0;
        ceros_arriba = '0;
        for (int i = 0; i < 4; i++) begin
            nib_cero[i] = (num_sel[4*i +: 4] == 4'h0);
        end
        ceros_arriba[3] = nib_cero[3];
        for (int i = 2; i >= 0; i--) begin
            ceros_arriba[i] = nib_cero[i] && ceros_arriba[i+1];
        end
    end

    assign blanco = sup_sel && (indice_d != 2'd0) && ceros_arriba[indice_d];

    always_comb begin
        contador_d  = tick ? '0 : contador_q + CW'(1);
        indice_d    = tick ? indice_q + 2'd1 : indice_q;
        copia_d     = copia_q;
        copia_sup_d = copia_sup_q;
        copia_pto_d = copia_pto_q;
        anodos_d    = anodos_q;
        segmentos_d = segmentos_q;
        punto_d     = punto_q;

        if (inicio_cuadro) begin
            copia_d     = numero;
            copia_sup_d = suprimir_ceros;
            copia_pto_d = punto_en;
        end

        if (tick) begin
            anodos_d    = anodo_activo(indice_d);
            segmentos_d = blanco ? SEG_APAGADO : seg_fuente;
            punto_d     = ~pto_sel[indice_d];
        end
    end

    // Index resets to 3 so the first tick lands on digit 0 and snapshots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador_q  <= '0;
            indice_q    <= 2'd3;
            copia_q     <= '0;
            copia_sup_q <= 1'b0;
            copia_pto_q <= 4'b0000;
            anodos_q    <= ANODOS_OFF;
            segmentos_q <= SEG_APAGADO;
            punto_q     <= 1'b1;
        end else begin
            contador_q  <= contador_d;
            indice_q    <= indice_d;
            copia_q     <= copia_d;
            copia_sup_q <= copia_sup_d;
            copia_pto_q <= copia_pto_d;
            anodos_q    <= anodos_d;
            segmentos_q <= segmentos_d;
            punto_q     <= punto_d;
        end
    end

    assign anodos    = anodos_q;
    assign segmentos = segmentos_q;
    assign punto     = punto_q;

endmodule

// File: tb/tb_controlador_7seg.sv
// -----------------------------------------------------------------------------
// tb_controlador_7seg
// Scoreboard bench, DIV_REFRESCO = 4. Expected digit slots for a frame are
// queued when the frame's inputs are driven and popped as each slot appears.
// -----------------------------------------------------------------------------
module tb_controlador_7seg;

    logic        clk;
    logic        reset;
    logic [15:0] numero;
    logic        suprimir_ceros;
    logic [3:0]  punto_en;
    logic [3:0]  anodos;
    logic [6:0]  segmentos;
    logic        punto;

    controlador_7seg #(
        .CANT_BITS    (16),
        .DIV_REFRESCO (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .numero         (numero),
        .suprimir_ceros (suprimir_ceros),
        .punto_en       (punto_en),
        .anodos         (anodos),
        .segmentos      (segmentos),
        .punto          (punto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       pt;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] last_an = 4'b1111;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic push_frame(input logic [15:0] num, input logic sup, input logic [3:0] pto);
        exp_t       e;
        logic [15:0] resto;
        for (int i = 0; i < 4; i++) begin
            resto = num >> (4 * i);
            e.an  = 4'b1111;
            e.an[i] = 1'b0;
            e.seg = (sup && i > 0 && resto == 16'h0) ? 7'h7F : font(resto[3:0]);
            e.pt  = ~pto[i];
            sb.push_back(e);
        end
    endtask

    task automatic check_slot();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got no expectation, expected one queued");
        end else begin
            e = sb.pop_front();
            chk("anodos",    16'(anodos),    16'(e.an));
            chk("segmentos", 16'(segmentos), 16'(e.seg));
            chk("punto",     16'(punto),     16'(e.pt));
            last_an = e.an;
        end
    endtask

    // Each slot is 4 edges; mid-slot the anodes must still hold the previous digit.
    task automatic run_slots(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (2) @(posedge clk);
            #1 chk("hold_an", 16'(anodos), 16'(last_an));
            repeat (2) @(posedge clk);
            #1 check_slot();
        end
    endtask

    initial begin
        reset          = 1'b1;
        numero         = 16'h1234;
        suprimir_ceros = 1'b0;
        punto_en       = 4'b0000;

        // Dark while reset held, clock running
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an",  16'(anodos),    16'hF);
        chk("rst_seg", 16'(segmentos), 16'h7F);
        chk("rst_pt",  16'(punto),     16'h1);

        @(negedge clk) reset = 1'b0;
        push_frame(16'h1234, 1'b0, 4'b0000);
        run_slots(4);

        // Leading-zero blanking with a non-zero digit in the middle
        numero = 16'h00A0; suprimir_ceros = 1'b1;
        push_frame(16'h00A0, 1'b1, 4'b0000);
        run_slots(4);

        // All zero: only digit 0 lit
        numero = 16'h0000;
        push_frame(16'h0000, 1'b1, 4'b0000);
        run_slots(4);

        // Blank digits still carry their decimal points
        punto_en = 4'b1111;
        push_frame(16'h0000, 1'b1, 4'b1111);
        run_slots(4);

        // Mid-frame change must not tear the frame
        numero = 16'hBEEF; suprimir_ceros = 1'b0; punto_en = 4'b0000;
        push_frame(16'hBEEF, 1'b0, 4'b0000);
        run_slots(3);
        numero = 16'hC0DE; punto_en = 4'b1111; suprimir_ceros = 1'b1;
        run_slots(1);
        numero = 16'hC0DE; suprimir_ceros = 1'b0; punto_en = 4'b0000;
        push_frame(16'hC0DE, 1'b0, 4'b0000);
        run_slots(4);

        // Single decimal point on digit 2
        numero = 16'h1234; punto_en = 4'b0100;
        push_frame(16'h1234, 1'b0, 4'b0100);
        run_slots(4);

        // Asynchronous reset while digit 1 is shown
        punto_en = 4'b0000;
        push_frame(16'h1234, 1'b0, 4'b0000);
        run_slots(2);
        #2 reset = 1'b1;
        #1;
        chk("arst_an",  16'(anodos),    16'hF);
        chk("arst_seg", 16'(segmentos), 16'h7F);
        chk("arst_pt",  16'(punto),     16'h1);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        last_an = 4'b1111;
        numero = 16'h5A0D;
        push_frame(16'h5A0D, 1'b0, 4'b0000);
        repeat (3) @(posedge clk);
        #1 chk("arst_dark3", 16'(anodos), 16'hF);
        @(posedge clk);
        #1 check_slot();
        run_slots(3);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_left: got %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
